// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider, h/v counters, phase decode and registered RGB/sync outputs.
// Optional feature macro VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern selected by TEST_MODE.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 4,
    parameter int   R_W      = 3,
    parameter int   G_W      = 3,
    parameter int   B_W      = 2,
    parameter int   X_W      = 10,
    parameter int   Y_W      = 10
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           TEST_MODE,
    input  logic [R_W-1:0] PIX_R_IN,
    input  logic [G_W-1:0] PIX_G_IN,
    input  logic [B_W-1:0] PIX_B_IN,
    output logic [X_W-1:0] PIX_X,
    output logic [Y_W-1:0] PIX_Y,
    output logic           PIX_VALID,
    output logic [R_W-1:0] VGA_RED,
    output logic [G_W-1:0] VGA_GREEN,
    output logic [B_W-1:0] VGA_BLUE,
    output logic           VGA_HSYNC,
    output logic           VGA_VSYNC,
    output logic           FRAME_START,
    output logic           VBLANK
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST      = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT_END   = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]   H_SYNC_BEG  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   H_SYNC_END  = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   V_LAST      = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_ACT_END   = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]   V_SYNC_BEG  = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   V_SYNC_END  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

    logic [DIV_W-1:0] r_div;
    logic [X_W-1:0]   r_h;
    logic [Y_W-1:0]   r_v;
    logic [R_W-1:0]   r_red;
    logic [G_W-1:0]   r_green;
    logic [B_W-1:0]   r_blue;
    logic             r_hsync;
    logic             r_vsync;

    logic             w_pix_en;
    logic             w_pix_valid;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    logic [R_W-1:0]   w_src_r;
    logic [G_W-1:0]   w_src_g;
    logic [B_W-1:0]   w_src_b;

    // Reset gates pix_en so that PIX_VALID/FRAME_START stay low during reset even when CLK_DIV=1.
    assign w_pix_en = (r_div == DIV_LAST) && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_en) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                if (r_v == V_LAST) begin
                    r_v <= '0;
                end else begin
                    r_v <= r_v + Y_W'(1);
                end
            end else begin
                r_h <= r_h + X_W'(1);
            end
        end
    end

    always_comb begin
        w_h_phase = PH_BP;
        if (r_h < H_ACT_END) begin
            w_h_phase = PH_ACTIVE;
        end else if (r_h < H_SYNC_BEG) begin
            w_h_phase = PH_FP;
        end else if (r_h < H_SYNC_END) begin
            w_h_phase = PH_SYNC;
        end
    end

    always_comb begin
        w_v_phase = PH_BP;
        if (r_v < V_ACT_END) begin
            w_v_phase = PH_ACTIVE;
        end else if (r_v < V_SYNC_BEG) begin
            w_v_phase = PH_FP;
        end else if (r_v < V_SYNC_END) begin
            w_v_phase = PH_SYNC;
        end
    end

    assign w_pix_valid = w_pix_en && (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar;

    // Bar width is H_ACTIVE/8, so H_ACTIVE must be at least 8 in this build.
    assign w_bar   = 3'(r_h / X_W'(H_ACTIVE / 8));
    assign w_src_r = TEST_MODE ? {R_W{w_bar[2]}} : PIX_R_IN;
    assign w_src_g = TEST_MODE ? {G_W{w_bar[1]}} : PIX_G_IN;
    assign w_src_b = TEST_MODE ? {B_W{w_bar[0]}} : PIX_B_IN;
`else
    logic w_test_mode_unused;

    assign w_test_mode_unused = TEST_MODE;
    assign w_src_r = PIX_R_IN;
    assign w_src_g = PIX_G_IN;
    assign w_src_b = PIX_B_IN;
`endif

    // Colour and both syncs load on the same pix_en edge, keeping them aligned; VSYNC can only
    // change when the v count changes, which happens only at h==0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
        end else if (w_pix_en) begin
            r_red   <= w_pix_valid ? w_src_r : '0;
            r_green <= w_pix_valid ? w_src_g : '0;
            r_blue  <= w_pix_valid ? w_src_b : '0;
            r_hsync <= (w_h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            r_vsync <= (w_v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
        end
    end

    assign PIX_X       = r_h;
    assign PIX_Y       = r_v;
    assign PIX_VALID   = w_pix_valid;
    assign FRAME_START = w_pix_en && (r_h == '0) && (r_v == '0);
    assign VBLANK      = (r_v >= V_ACT_END);
    assign VGA_RED     = r_red;
    assign VGA_GREEN   = r_green;
    assign VGA_BLUE    = r_blue;
    assign VGA_HSYNC   = r_hsync;
    assign VGA_VSYNC   = r_vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using two small rasters (14x7 counts):
// u_a divides by 2 with active-low syncs, u_b runs at CLK_DIV=1 with active-high syncs.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       test_mode;
    logic [2:0] pr;
    logic [2:0] pg;
    logic [1:0] pb;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_valid, b_valid, a_hs, b_hs, a_vs, b_vs, a_fs, b_fs, a_vb, b_vb;
    logic [2:0] a_r, a_g, b_r, b_g;
    logic [1:0] a_b, b_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2)
    ) u_a (
        .CLK(clk), .RESET(rst), .TEST_MODE(test_mode),
        .PIX_R_IN(pr), .PIX_G_IN(pg), .PIX_B_IN(pb),
        .PIX_X(a_x), .PIX_Y(a_y), .PIX_VALID(a_valid),
        .VGA_RED(a_r), .VGA_GREEN(a_g), .VGA_BLUE(a_b),
        .VGA_HSYNC(a_hs), .VGA_VSYNC(a_vs), .FRAME_START(a_fs), .VBLANK(a_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
    ) u_b (
        .CLK(clk), .RESET(rst), .TEST_MODE(test_mode),
        .PIX_R_IN(pr), .PIX_G_IN(pg), .PIX_B_IN(pb),
        .PIX_X(b_x), .PIX_Y(b_y), .PIX_VALID(b_valid),
        .VGA_RED(b_r), .VGA_GREEN(b_g), .VGA_BLUE(b_b),
        .VGA_HSYNC(b_hs), .VGA_VSYNC(b_vs), .FRAME_START(b_fs), .VBLANK(b_vb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int         a_hs_lo, a_vs_lo, a_fs_n, a_val_n, a_red_n, a_vb_n;
        int         b_hs_hi, b_vs_hi, b_fs_n, b_val_n, b_red_n;
        int         lat_err, vs_err, vb_err, b_fs_first, b_fs_period;
        int         a_hs_fall0, a_hs_period, pat_err, pat_n;
        logic       p_a_valid, p_b_valid, p_a_vs, p_b_vs, p_a_hs;
        logic [9:0] p_a_x, p_b_x;
        logic [2:0] e_r, e_g;
        logic [1:0] e_b;
        bit         found;

        rst = 1'b1; test_mode = 1'b0; pr = 3'd5; pg = 3'd2; pb = 2'd1;
        repeat (5) tick();

        check("rst_a_x", 32'(a_x), 32'd0);
        check("rst_a_y", 32'(a_y), 32'd0);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_fs", 32'(a_fs), 32'd0);
        check("rst_a_hsync", 32'(a_hs), 32'd1);
        check("rst_a_vsync", 32'(a_vs), 32'd1);
        check("rst_a_red", 32'(a_r), 32'd0);
        check("rst_b_hsync", 32'(b_hs), 32'd0);
        check("rst_b_vsync", 32'(b_vs), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_b_fs", 32'(b_fs), 32'd0);

        // Release: u_b (div 1) sees pix_en at (0,0) at once; u_a needs a full 2-cycle count.
        rst = 1'b0;
        #1;
        check("rel_a_fs_early", 32'(a_fs), 32'd0);
        check("rel_b_fs", 32'(b_fs), 32'd1);
        check("rel_b_valid", 32'(b_valid), 32'd1);

        tick();
        check("e1_a_fs", 32'(a_fs), 32'd1);
        check("e1_a_valid", 32'(a_valid), 32'd1);
        check("e1_a_x", 32'(a_x), 32'd0);
        check("e1_a_red", 32'(a_r), 32'd0);
        check("e1_b_x", 32'(b_x), 32'd1);
        check("e1_b_red", 32'(b_r), 32'd5);
        check("e1_b_fs", 32'(b_fs), 32'd0);

        tick();
        check("e2_a_red", 32'(a_r), 32'd5);
        check("e2_a_green", 32'(a_g), 32'd2);
        check("e2_a_blue", 32'(a_b), 32'd1);
        check("e2_a_x", 32'(a_x), 32'd1);
        check("e2_a_valid", 32'(a_valid), 32'd0);

        // One u_a frame (196 CLK) = two u_b frames; totals hold for any window of that length.
        a_hs_lo = 0; a_vs_lo = 0; a_fs_n = 0; a_val_n = 0; a_red_n = 0; a_vb_n = 0;
        b_hs_hi = 0; b_vs_hi = 0; b_fs_n = 0; b_val_n = 0; b_red_n = 0;
        lat_err = 0; vs_err = 0; vb_err = 0; b_fs_first = -1; b_fs_period = 0;
        a_hs_fall0 = -1; a_hs_period = 0;
        p_a_valid = a_valid; p_b_valid = b_valid; p_a_vs = a_vs; p_b_vs = b_vs;
        p_a_hs = a_hs; p_a_x = a_x; p_b_x = b_x;
        for (int c = 0; c < 196; c++) begin
            tick();
            if (!a_hs) a_hs_lo++;
            if (!a_vs) a_vs_lo++;
            if (a_fs) a_fs_n++;
            if (a_valid) a_val_n++;
            if (a_r == 3'd5) a_red_n++;
            if (a_vb) a_vb_n++;
            if (b_hs) b_hs_hi++;
            if (b_vs) b_vs_hi++;
            if (b_val_n >= 0 && b_valid) b_val_n++;
            if (b_r == 3'd5) b_red_n++;
            if (b_fs) begin
                b_fs_n++;
                if (b_fs_first < 0) b_fs_first = c;
                else if (b_fs_period == 0) b_fs_period = c - b_fs_first;
            end
            if (p_a_hs && !a_hs) begin
                if (a_hs_fall0 < 0) a_hs_fall0 = c;
                else if (a_hs_period == 0) a_hs_period = c - a_hs_fall0;
            end
            if (p_a_valid && a_r != 3'd5) lat_err++;
            if (p_b_valid != (b_r == 3'd5)) lat_err++;
            if (a_vs != p_a_vs && p_a_x != 10'd0) vs_err++;
            if (b_vs != p_b_vs && p_b_x != 10'd0) vs_err++;
            if ((a_vb && a_r != 3'd0) || (b_vb && b_r != 3'd0)) vb_err++;
            p_a_valid = a_valid; p_b_valid = b_valid; p_a_vs = a_vs; p_b_vs = b_vs;
            p_a_hs = a_hs; p_a_x = a_x; p_b_x = b_x;
        end
        check("a_hsync_low_clks", 32'(a_hs_lo), 32'd28);
        check("a_hsync_period", 32'(a_hs_period), 32'd28);
        check("a_vsync_low_clks", 32'(a_vs_lo), 32'd28);
        check("a_frame_starts", 32'(a_fs_n), 32'd1);
        check("a_valid_count", 32'(a_val_n), 32'd32);
        check("a_red_clks", 32'(a_red_n), 32'd64);
        check("a_vblank_clks", 32'(a_vb_n), 32'd84);
        check("b_hsync_high_clks", 32'(b_hs_hi), 32'd28);
        check("b_vsync_high_clks", 32'(b_vs_hi), 32'd28);
        check("b_frame_starts", 32'(b_fs_n), 32'd2);
        check("b_frame_period", 32'(b_fs_period), 32'd98);
        check("b_valid_count", 32'(b_val_n), 32'd64);
        check("b_red_clks", 32'(b_red_n), 32'd64);
        check("colour_latency_errs", 32'(lat_err), 32'd0);
        check("vsync_midline_errs", 32'(vs_err), 32'd0);
        check("vblank_colour_errs", 32'(vb_err), 32'd0);

        // Mid-frame reset while u_a is on an active pixel.
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            tick();
            if (a_x == 10'd3 && a_y == 10'd2 && a_valid) found = 1'b1;
        end
        check("wait_a_3_2", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_a_red", 32'(a_r), 32'd0);
        check("mid_rst_a_hsync", 32'(a_hs), 32'd1);
        check("mid_rst_a_vsync", 32'(a_vs), 32'd1);
        check("mid_rst_a_x", 32'(a_x), 32'd0);
        check("mid_rst_a_y", 32'(a_y), 32'd0);
        check("mid_rst_b_hsync", 32'(b_hs), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rel_a_fs_early", 32'(a_fs), 32'd0);
        tick();
        check("mid_rel_a_fs", 32'(a_fs), 32'd1);

        // TEST_MODE: bars of width 1 in this raster when the pattern is built, else pass-through.
        pr = 3'd3; pg = 3'd6; pb = 2'd2; test_mode = 1'b1;
        pat_err = 0; pat_n = 0;
        p_b_valid = b_valid; p_b_x = b_x;
        for (int c = 0; c < 98; c++) begin
            tick();
            if (p_b_valid) begin
`ifdef VGA_TEST_PATTERN_EN
                e_r = p_b_x[2] ? 3'd7 : 3'd0;
                e_g = p_b_x[1] ? 3'd7 : 3'd0;
                e_b = p_b_x[0] ? 2'd3 : 2'd0;
`else
                e_r = 3'd3; e_g = 3'd6; e_b = 2'd2;
`endif
                pat_n++;
                if (b_r != e_r || b_g != e_g || b_b != e_b) pat_err++;
            end
            p_b_valid = b_valid; p_b_x = b_x;
        end
        check("tm_pixels_seen", 32'(pat_n), 32'd32);
        check("tm_colour_errs", 32'(pat_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
